// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file: default geometry,
// the stack-pointer seed used by the post-reset sweep, and the sweep FSM states.
package rf_pkg;

  localparam int          RF_XLEN    = 32;
  localparam int          RF_NREG    = 32;
  localparam int          RF_SP_IDX  = 2;
  localparam logic [31:0] RF_SP_INIT = 32'h100;

  typedef enum logic {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_t;

endpackage

// File: rtl/rf_init_seq.sv
// Post-reset initialisation sequencer. Walks every register index once,
// presenting a write of zero (or the stack-pointer seed at SP_IDX), then
// parks in RUN and raises ready until the next reset.
module rf_init_seq
  import rf_pkg::*;
#(
  parameter int              XLEN    = RF_XLEN,
  parameter int              NREG    = RF_NREG,
  parameter int              AW      = $clog2(NREG),
  parameter int              SP_IDX  = RF_SP_IDX,
  parameter logic [XLEN-1:0] SP_INIT = XLEN'(RF_SP_INIT)
) (
  input  logic            clk,
  input  logic            reset,
  output logic            ready,
  output logic            init_we,
  output logic [AW-1:0]   init_addr,
  output logic [XLEN-1:0] init_data
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);
  localparam logic [AW-1:0] SP_ADDR  = AW'(SP_IDX);
  localparam bit            SP_OK    = (SP_IDX > 0) && (SP_IDX < NREG);

  rf_state_t       state;
  rf_state_t       state_next;
  logic [AW-1:0]   idx;
  logic [AW-1:0]   idx_next;

  // State and sweep index; reset restarts the sweep from index 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RF_INIT;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // Advance the index each cycle; on the last index move to RUN and hold the
  // index there so a non-power-of-two register count never wraps.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    if (state == RF_INIT) begin
      if (idx == LAST_IDX) begin
        state_next = RF_RUN;
      end else begin
        idx_next = idx + 1'b1;
      end
    end
  end

  assign ready     = (state == RF_RUN);
  assign init_we   = (state == RF_INIT);
  assign init_addr = idx;
  assign init_data = (SP_OK && (idx == SP_ADDR)) ? SP_INIT : '0;

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-port integer register file. The storage array has no
// reset; a post-reset sweep (rf_init_seq) clears it and seeds the stack
// pointer, and ready is held low until that sweep finishes.
// Optional build macro RF_BYPASS_EN: forwards a same-cycle legal write to
// any read port addressing the same register.
module reg_file_mp
  import rf_pkg::*;
#(
  parameter int              XLEN    = RF_XLEN,
  parameter int              NREG    = RF_NREG,
  parameter int              AW      = $clog2(NREG),
  parameter int              NRP     = 2,
  parameter int              NWP     = 1,
  parameter int              SP_IDX  = RF_SP_IDX,
  parameter logic [XLEN-1:0] SP_INIT = XLEN'(RF_SP_INIT)
) (
  input  logic                clk,
  input  logic                reset,
  output logic                ready,
  input  logic [NRP*AW-1:0]   rd_addr,
  output logic [NRP*XLEN-1:0] rd_data,
  input  logic [NWP-1:0]      we,
  input  logic [NWP*AW-1:0]   wr_addr,
  input  logic [NWP*XLEN-1:0] wr_data
);

  localparam logic [AW:0] NREG_EXT = (AW + 1)'(NREG);

  logic [XLEN-1:0] mem [NREG];
  logic            init_we;
  logic [AW-1:0]   init_addr;
  logic [XLEN-1:0] init_data;

  // A register address is usable when it is neither x0 nor beyond the array.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != '0) && ({1'b0, a} < NREG_EXT);
  endfunction

  rf_init_seq #(
    .XLEN    (XLEN),
    .NREG    (NREG),
    .AW      (AW),
    .SP_IDX  (SP_IDX),
    .SP_INIT (SP_INIT)
  ) u_init_seq (
    .clk       (clk),
    .reset     (reset),
    .ready     (ready),
    .init_we   (init_we),
    .init_addr (init_addr),
    .init_data (init_data)
  );

  // Sweep writes take priority and lock out the ports; in RUN the ports are
  // applied in ascending order so the highest-numbered port wins a collision.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_addr] <= init_data;
    end else begin
      for (int j = 0; j < NWP; j++) begin
        if (we[j] && addr_ok(wr_addr[j*AW +: AW])) begin
          mem[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
        end
      end
    end
  end

  // Combinational reads; zero for x0, out-of-range addresses and during the sweep.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NRP; k++) begin
      if (ready && addr_ok(rd_addr[k*AW +: AW])) begin
        rd_data[k*XLEN +: XLEN] = mem[rd_addr[k*AW +: AW]];
`ifdef RF_BYPASS_EN
        for (int j = 0; j < NWP; j++) begin
          if (we[j] && addr_ok(wr_addr[j*AW +: AW]) &&
              (wr_addr[j*AW +: AW] == rd_addr[k*AW +: AW])) begin
            rd_data[k*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp with NREG=24, four read ports and two
// write ports. Stimulus pushes expected values tagged with the cycle they
// apply to; a monitor on the falling edge pops and compares them.
module tb_reg_file_mp;

  localparam int XLEN = 32;
  localparam int NREG = 24;
  localparam int AW   = $clog2(NREG);
  localparam int NRP  = 4;
  localparam int NWP  = 2;

`ifdef RF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct {
    string           name;
    int              port;
    logic [XLEN-1:0] value;
    int              cyc;
  } exp_t;

  logic                clk;
  logic                reset;
  logic                ready;
  logic [NRP*AW-1:0]   rd_addr;
  logic [NRP*XLEN-1:0] rd_data;
  logic [NWP-1:0]      we;
  logic [NWP*AW-1:0]   wr_addr;
  logic [NWP*XLEN-1:0] wr_data;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  reg_file_mp #(
    .XLEN (XLEN),
    .NREG (NREG),
    .NRP  (NRP),
    .NWP  (NWP)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .ready   (ready),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .we      (we),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to tag expectations.
  always @(posedge clk) begin
    cyc <= cyc + 1;
  end

  // Monitor: mid-cycle, compare every expectation queued for this cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      automatic exp_t            e = exp_q.pop_front();
      automatic logic [XLEN-1:0] act;
      if (e.port < 0) act = {{(XLEN-1){1'b0}}, ready};
      else            act = rd_data[e.port*XLEN +: XLEN];
      checks++;
      if (e.cyc != cyc) begin
        errors++;
        $display("[TB] FAIL %s: stale expectation from cycle %0d seen at cycle %0d", e.name, e.cyc, cyc);
      end else if (act !== e.value) begin
        errors++;
        $display("[TB] FAIL %s: port %0d got %h expected %h", e.name, e.port, act, e.value);
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [NWP-1:0] w_en,
                               input int wa0, input logic [XLEN-1:0] wd0,
                               input int wa1, input logic [XLEN-1:0] wd1,
                               input int ra0, input int ra1,
                               input int ra2, input int ra3);
    we      = w_en;
    wr_addr = {AW'(wa1), AW'(wa0)};
    wr_data = {wd1, wd0};
    rd_addr = {AW'(ra3), AW'(ra2), AW'(ra1), AW'(ra0)};
  endtask

  task automatic checkOutput(input string name, input int port, input logic [XLEN-1:0] value);
    exp_t e;
    e.name  = name;
    e.port  = port;
    e.value = value;
    e.cyc   = cyc;
    exp_q.push_back(e);
  endtask

  task automatic checkAll(input string name,
                          input logic [XLEN-1:0] v0, input logic [XLEN-1:0] v1,
                          input logic [XLEN-1:0] v2, input logic [XLEN-1:0] v3);
    checkOutput(name, 0, v0);
    checkOutput(name, 1, v1);
    checkOutput(name, 2, v2);
    checkOutput(name, 3, v3);
  endtask

  task automatic sweep(input string name);
    for (int e = 1; e <= NREG; e++) begin
      step();
      checkOutput(name, -1, (e == NREG) ? 1 : 0);
      if (e < NREG) checkOutput({name, "_rd_x2"}, 0, 0);
    end
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(2'b11, 5, 32'hDEAD, 5, 32'hDEAD, 2, 5, 0, 1);

    // Reset held three cycles with writes requested throughout.
    repeat (3) begin
      step();
      checkOutput("reset_ready", -1, 0);
      checkOutput("reset_rd_x2", 0, 0);
    end
    reset = 1'b0;

    // Sweep: ready low for NREG-1 edges, high at the NREG-th.
    sweep("sweep_ready");
    applyStimulus(2'b00, 0, 0, 0, 0, 2, 5, 0, 1);
    checkAll("post_sweep", 32'h100, 0, 0, 0);

    step();
    applyStimulus(2'b00, 0, 0, 0, 0, 3, 23, 22, 4);
    checkAll("post_sweep_zero", 0, 0, 0, 0);

    // Single write to x7, same-cycle and next-cycle reads.
    step();
    applyStimulus(2'b01, 7, 32'h1234, 0, 0, 7, 2, 0, 0);
    checkAll("wr_x7_same", BYPASS ? 32'h1234 : 32'h0, 32'h100, 0, 0);
    step();
    applyStimulus(2'b00, 0, 0, 0, 0, 7, 2, 0, 9);
    checkAll("wr_x7_next", 32'h1234, 32'h100, 0, 0);

    // Both ports hit x9: higher port wins.
    step();
    applyStimulus(2'b11, 9, 32'hA, 9, 32'hB, 9, 7, 0, 0);
    checkAll("dual_x9_same", BYPASS ? 32'hB : 32'h0, 32'h1234, 0, 0);
    step();
    applyStimulus(2'b00, 0, 0, 0, 0, 9, 7, 0, 0);
    checkAll("dual_x9_next", 32'hB, 32'h1234, 0, 0);

    // Writes to x0 and to an out-of-range address are dropped.
    step();
    applyStimulus(2'b11, 0, 32'hFFFF_FFFF, 30, 32'h55, 0, 30, 7, 9);
    checkAll("drop_same", 0, 0, 32'h1234, 32'hB);
    step();
    applyStimulus(2'b00, 0, 0, 0, 0, 0, 30, 7, 9);
    checkAll("drop_next", 0, 0, 32'h1234, 32'hB);

    // Last legal register and more registers for the multi-read check.
    step();
    applyStimulus(2'b11, 23, 32'h77, 10, 32'h10A, 23, 10, 22, 1);
    checkAll("wr_top_same", BYPASS ? 32'h77 : 32'h0, BYPASS ? 32'h10A : 32'h0, 0, 0);
    step();
    applyStimulus(2'b11, 11, 32'h11B, 12, 32'h12C, 23, 10, 22, 1);
    checkAll("wr_top_next", 32'h77, 32'h10A, 0, 0);
    step();
    applyStimulus(2'b00, 0, 0, 0, 0, 7, 9, 10, 11);
    checkAll("multi_read_a", 32'h1234, 32'hB, 32'h10A, 32'h11B);
    step();
    applyStimulus(2'b00, 0, 0, 0, 0, 12, 11, 23, 2);
    checkAll("multi_read_b", 32'h12C, 32'h11B, 32'h77, 32'h100);

    // Asynchronous reset between edges while in RUN.
    step();
    #3;
    reset = 1'b1;
    applyStimulus(2'b00, 0, 0, 0, 0, 7, 2, 9, 23);
    checkOutput("async_reset_ready", -1, 0);
    checkAll("async_reset_rd", 0, 0, 0, 0);
    step();
    checkOutput("reset_hold_ready", -1, 0);
    step();
    reset = 1'b0;

    // Partial sweep interrupted by reset must restart from index 0.
    repeat (10) step();
    checkOutput("mid_sweep_ready", -1, 0);
    reset = 1'b1;
    step();
    checkOutput("mid_reset_ready", -1, 0);
    reset = 1'b0;

    sweep("resweep_ready");
    applyStimulus(2'b00, 0, 0, 0, 0, 2, 7, 9, 23);
    checkAll("resweep_rd_a", 32'h100, 0, 0, 0);
    step();
    applyStimulus(2'b00, 0, 0, 0, 0, 11, 12, 10, 1);
    checkAll("resweep_rd_b", 0, 0, 0, 0);

    step();
    step();
    if (exp_q.size() != 0) begin
      checks += exp_q.size();
      errors += exp_q.size();
      $display("[TB] FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
